// File: rtl/gate_response_checker_pkg.sv
// Shared types and helpers for the gate response checker: op/state enums, bin count and the
// reference gate model used to judge each observed transaction.
package gate_chk_pkg;

  localparam int unsigned NUM_BINS = 16;

  typedef enum logic [1:0] {
    OpAnd  = 2'd0,
    OpOr   = 2'd1,
    OpXor  = 2'd2,
    OpNand = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } chk_state_e;

  function automatic logic gate_exp(gate_op_e op, logic a, logic b);
    logic y;
    unique case (op)
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpNand:  y = ~(a & b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Observed-transaction channel: the stimulus side presents op/operands/DUT output with a
// valid/ready handshake; the checker is the slave.
interface gate_response_checker_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic       in_a;
  logic       in_b;
  logic       in_y;

  modport master (
    output in_valid,
    output in_op,
    output in_a,
    output in_b,
    output in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_a,
    input  in_b,
    input  in_y,
    output in_ready
  );

endinterface

// File: rtl/gate_response_checker_cov_bins.sv
// Sticky 16-bin coverage bitmap with registered popcount and floor percentage.
// full reflects the bitmap as it will be after this edge, so the FSM can leave RUN on that edge.
module gate_cov_bins
  import gate_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hit,
  input  logic [3:0] idx,
  output logic [4:0] hits,
  output logic [6:0] pct,
  output logic       full
);

  logic [NUM_BINS-1:0] bits_q, bits_d;
  logic [4:0]          hits_q, hits_d;
  logic [6:0]          pct_q, pct_d;
  logic [11:0]         prod;

  always_comb begin
    bits_d = bits_q;
    if (clear) begin
      bits_d = '0;
    end else if (hit) begin
      bits_d[idx] = 1'b1;
    end

    hits_d = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      hits_d = hits_d + 5'(bits_d[i]);
    end

    // 16 bins: divide by 16 is a shift, which truncates exactly as floor requires.
    prod  = {7'b0, hits_d} * 12'd100;
    pct_d = prod[10:4];
  end

  assign full = &bits_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      hits_q <= '0;
      pct_q  <= '0;
    end else begin
      bits_q <= bits_d;
      hits_q <= hits_d;
      pct_q  <= pct_d;
    end
  end

  assign hits = hits_q;
  assign pct  = pct_q;

endmodule

// File: rtl/gate_response_checker.sv
// Checks observed gate transactions against a reference model, counting transfers and
// mismatches and tracking {op,a,b} coverage; a run ends once all 16 bins are hit.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  gate_response_checker_if.slave    bus,
  output logic [CNT_W-1:0]          txn_count,
  output logic [CNT_W-1:0]          err_count,
  output logic                      mismatch,
  output logic [4:0]                cov_hits,
  output logic [6:0]                cov_pct,
  output logic                      done
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             mis_q, mis_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic xfer, exp_y, bad, start_run, cov_full;

  assign xfer      = bus.in_valid & ready_q;
  assign exp_y     = gate_exp(gate_op_e'(bus.in_op), bus.in_a, bus.in_b);
  assign bad       = xfer & (bus.in_y != exp_y);
  assign start_run = start & (state_q != StRun);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (xfer && cov_full) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  always_comb begin
    txn_d = txn_q;
    err_d = err_q;
    mis_d = 1'b0;
    if (start_run) begin
      txn_d = '0;
      err_d = '0;
    end else if (xfer) begin
      if (!(&txn_q)) txn_d = txn_q + 1'b1;
      if (bad && !(&err_q)) err_d = err_q + 1'b1;
      mis_d = bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      txn_q   <= '0;
      err_q   <= '0;
      mis_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  gate_cov_bins u_cov (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run),
    .hit   (xfer),
    .idx   ({bus.in_op, bus.in_a, bus.in_b}),
    .hits  (cov_hits),
    .pct   (cov_pct),
    .full  (cov_full)
  );

  assign bus.in_ready = ready_q;
  assign txn_count    = txn_q;
  assign err_count    = err_q;
  assign mismatch     = mis_q;
  assign done         = done_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: drives a 16-bit and a 4-bit counter instance in lockstep, models expected
// results per step, queues them and compares after each clock edge.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  gate_response_checker_if bus16 ();
  gate_response_checker_if bus4 ();

  logic [15:0] txn16, err16;
  logic [3:0]  txn4, err4;
  logic        mis16, mis4, done16, done4;
  logic [4:0]  hits16, hits4;
  logic [6:0]  pct16, pct4;

  gate_response_checker #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus16),
    .txn_count (txn16),
    .err_count (err16),
    .mismatch  (mis16),
    .cov_hits  (hits16),
    .cov_pct   (pct16),
    .done      (done16)
  );

  gate_response_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus4),
    .txn_count (txn4),
    .err_count (err4),
    .mismatch  (mis4),
    .cov_hits  (hits4),
    .cov_pct   (pct4),
    .done      (done4)
  );

  typedef struct packed {
    logic [15:0] txn;
    logic [15:0] err;
    logic        mis;
    logic [4:0]  hits;
    logic [6:0]  pct;
    logic        done;
    logic        ready;
    logic [3:0]  txn4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0 idle, 1 run, 2 done.
  int          m_state;
  int          m_txn, m_err, m_txn4;
  logic [15:0] m_bits;
  logic        m_mis;
  logic [3:0]  tt [4];

  function automatic exp_t snap();
    exp_t e;
    int   h;
    h       = $countones(m_bits);
    e.txn   = m_txn[15:0];
    e.err   = m_err[15:0];
    e.mis   = m_mis;
    e.hits  = h[4:0];
    e.pct   = 7'((h * 100) / 16);
    e.done  = (m_state == 2);
    e.ready = (m_state == 1);
    e.txn4  = m_txn4[3:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("txn_count", 32'(txn16), 32'(e.txn));
    chk("err_count", 32'(err16), 32'(e.err));
    chk("mismatch", 32'(mis16), 32'(e.mis));
    chk("cov_hits", 32'(hits16), 32'(e.hits));
    chk("cov_pct", 32'(pct16), 32'(e.pct));
    chk("done", 32'(done16), 32'(e.done));
    chk("in_ready", 32'(bus16.in_ready), 32'(e.ready));
    chk("txn_count_w4", 32'(txn4), 32'(e.txn4));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_txn   = 0;
    m_err   = 0;
    m_txn4  = 0;
    m_bits  = '0;
    m_mis   = 1'b0;
  endtask

  task automatic drive(input bit v, input int op, input bit a, input bit b, input bit y);
    bus16.in_valid = v;  bus4.in_valid = v;
    bus16.in_op = op[1:0]; bus4.in_op = op[1:0];
    bus16.in_a = a;      bus4.in_a = a;
    bus16.in_b = b;      bus4.in_b = b;
    bus16.in_y = y;      bus4.in_y = y;
  endtask

  task automatic step(input bit v, input bit st, input int op, input bit a, input bit b,
                      input bit y);
    logic [1:0] ab;
    @(negedge clk);
    drive(v, op, a, b, y);
    start = st;
    ab = {a, b};
    if (st && m_state != 1) begin
      model_reset();
      m_state = 1;
    end else if (v && m_state == 1) begin
      if (m_txn < 65535) m_txn++;
      if (m_txn4 < 15) m_txn4++;
      m_mis = (y != tt[op][ab]);
      if (m_mis) m_err++;
      m_bits[{op[1:0], ab}] = 1'b1;
      if (m_bits == 16'hFFFF) m_state = 2;
    end else begin
      m_mis = 1'b0;
    end
    sb.push_back(snap());
    @(posedge clk);
    #1;
    compare(sb.pop_front());
  endtask

  // Asynchronous reset landing between edges, optionally with a transfer pending.
  task automatic do_reset(input bit v);
    @(negedge clk);
    drive(v, 0, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare(snap());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic full_sweep(input bit flip_last);
    logic [3:0] bi;
    logic [1:0] ab;
    bit         y;
    for (int i = 0; i < 16; i++) begin
      bi = i[3:0];
      ab = bi[1:0];
      y  = tt[bi[3:2]][ab] ^ (flip_last && i == 15);
      step(1'b1, 1'b0, int'(bi[3:2]), bi[1], bi[0], y);
    end
  endtask

  initial begin
    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0110;  // XOR
    tt[3] = 4'b0111;  // NAND

    rst   = 1'b1;
    start = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    model_reset();
    compare(snap());
    #12;
    @(negedge clk);
    rst = 1'b0;

    repeat (3) step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);

    step(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);

    step(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);

    do_reset(1'b1);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    full_sweep(1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 3, i[0], i[1], ~(i[0] & i[1]));
    end
    do_reset(1'b1);
    repeat (3) step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);

    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    full_sweep(1'b1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
